// File: rtl/sysbus_mem_ctrl.sv
// ============================================================================
// Module   : sysbus_mem_ctrl
// Brief    : SysBus-to-async-SRAM access controller with wait states; returns
//            read data on DataIn with a MemEn strobe. Optional MemWait
//            extension enabled by macro MEMCTRL_EXT_WAIT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sysbus_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] SysBus,
    input  logic        Req,
    input  logic        Write,
    output logic        Ready,
    output logic        Done,
    output logic [15:0] DataIn,
    output logic        MemEn,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    output logic        nMemOE,
    output logic        nMemWE,
    input  logic        MemWait
);

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_ACCESS = 3'd2,
        S_RDONE  = 3'd3,
        S_WREC   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_is_write;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;

    logic        w_wait_clear;
    logic        w_load_addr;
    logic        w_load_wdata;
    logic        w_load_cnt;
    logic        w_dec_cnt;
    logic        w_capture;

`ifdef MEMCTRL_EXT_WAIT_EN
    assign w_wait_clear = ~MemWait;
`else
    logic w_unused_memwait;
    assign w_unused_memwait = MemWait;
    assign w_wait_clear     = 1'b1;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes depend only on state and the latched direction, never on Req/SysBus.
    always_comb begin
        w_next       = r_state;
        Ready        = 1'b0;
        Done         = 1'b0;
        MemEn        = 1'b0;
        nMemOE       = 1'b1;
        nMemWE       = 1'b1;
        w_load_addr  = 1'b0;
        w_load_wdata = 1'b0;
        w_load_cnt   = 1'b0;
        w_dec_cnt    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                Ready = 1'b1;
                if (Req) begin
                    w_load_addr = 1'b1;
                    if (Write) begin
                        w_next = S_WDATA;
                    end else begin
                        w_load_cnt = 1'b1;
                        w_next     = S_ACCESS;
                    end
                end
            end
            S_WDATA: begin
                w_load_wdata = 1'b1;
                w_load_cnt   = 1'b1;
                w_next       = S_ACCESS;
            end
            S_ACCESS: begin
                nMemOE    = r_is_write;
                nMemWE    = ~r_is_write;
                w_dec_cnt = (r_cnt != 4'd0);
                if ((r_cnt == 4'd0) && w_wait_clear) begin
                    if (r_is_write) begin
                        w_next = S_WREC;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = S_RDONE;
                    end
                end
            end
            S_RDONE: begin
                MemEn  = 1'b1;
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            S_WREC: begin
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_rdata    <= 16'h0000;
        end else begin
            if (w_load_addr) begin
                r_addr     <= SysBus;
                r_is_write <= Write;
            end
            if (w_load_wdata) begin
                r_wdata <= SysBus;
            end
            if (w_load_cnt) begin
                r_cnt <= C_WAIT_LOAD;
            end else if (w_dec_cnt) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rdata <= MemRData;
            end
        end
    end

    assign MemAddr  = r_addr;
    assign MemWData = r_wdata;
    assign DataIn   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sysbus_mem_ctrl.sv
// ============================================================================
// Module   : tb_sysbus_mem_ctrl
// Brief    : Directed self-checking bench for sysbus_mem_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sysbus_mem_ctrl;

    localparam int unsigned WS = 2;

    logic        Clock = 1'b0;
    logic        nReset;
    logic [15:0] SysBus;
    logic        Req;
    logic        Write;
    logic        Ready;
    logic        Done;
    logic [15:0] DataIn;
    logic        MemEn;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        nMemOE;
    logic        nMemWE;
    logic        MemWait;

    int n_cmp = 0;
    int n_bad = 0;

    sysbus_mem_ctrl #(.WAIT_STATES(WS)) u_dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .SysBus   (SysBus),
        .Req      (Req),
        .Write    (Write),
        .Ready    (Ready),
        .Done     (Done),
        .DataIn   (DataIn),
        .MemEn    (MemEn),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .nMemOE   (nMemOE),
        .nMemWE   (nMemWE),
        .MemWait  (MemWait)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int en_c;
        logic [15:0] en_data;
        int exp_en_c;
        logic [15:0] exp_en_data;

        nReset = 1'b0; Req = 1'b0; Write = 1'b0; SysBus = 16'h0000;
        MemRData = 16'h0000; MemWait = 1'b0;
        #12;
        check("rst_ready",  16'(Ready),  16'd1);
        check("rst_done",   16'(Done),   16'd0);
        check("rst_memen",  16'(MemEn),  16'd0);
        check("rst_datain", DataIn,      16'h0000);
        check("rst_addr",   MemAddr,     16'h0000);
        check("rst_wdata",  MemWData,    16'h0000);
        check("rst_oe",     16'(nMemOE), 16'd1);
        check("rst_we",     16'(nMemWE), 16'd1);
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);

        // Read 0x0040 -> 0xBEEF
        Req = 1'b1; Write = 1'b0; SysBus = 16'h0040; MemRData = 16'hBEEF;
        for (int k = 1; k <= int'(WS) + 3; k++) begin
            @(negedge Clock);
            Req = 1'b0; SysBus = 16'hFFFF;
            check("rd_oe",    16'(nMemOE), (k <= int'(WS) + 1) ? 16'd0 : 16'd1);
            check("rd_we",    16'(nMemWE), 16'd1);
            check("rd_memen", 16'(MemEn),  16'(k == int'(WS) + 2));
            check("rd_done",  16'(Done),   16'(k == int'(WS) + 2));
            check("rd_ready", 16'(Ready),  16'(k == int'(WS) + 3));
            check("rd_addr",  MemAddr,     16'h0040);
            if (k == int'(WS) + 2) check("rd_data", DataIn, 16'hBEEF);
        end

        // Write 0xA5A5 to 0x1234
        Req = 1'b1; Write = 1'b1; SysBus = 16'h1234;
        for (int k = 1; k <= int'(WS) + 4; k++) begin
            @(negedge Clock);
            check("wr_we",    16'(nMemWE), (k >= 2 && k <= int'(WS) + 2) ? 16'd0 : 16'd1);
            check("wr_oe",    16'(nMemOE), 16'd1);
            check("wr_done",  16'(Done),   16'(k == int'(WS) + 3));
            check("wr_memen", 16'(MemEn),  16'd0);
            check("wr_ready", 16'(Ready),  16'(k == int'(WS) + 4));
            check("wr_addr",  MemAddr,     16'h1234);
            if (k >= 2) check("wr_wdata", MemWData, 16'hA5A5);
            if (k == int'(WS) + 3) check("wr_datain_hold", DataIn, 16'hBEEF);
            Req = 1'b0; Write = 1'b0;
            SysBus = (k == 1) ? 16'hA5A5 : 16'hFFFF;
        end

        // Read 0x0100 with a Req pulsed while busy
        Req = 1'b1; Write = 1'b0; SysBus = 16'h0100; MemRData = 16'h1111;
        c = 0;
        do begin
            @(negedge Clock);
            c++;
            Req = 1'b0; Write = 1'b0; SysBus = 16'hFFFF;
            if (c == 2) begin
                Req = 1'b1; Write = 1'b1; SysBus = 16'h9999;
            end
        end while (!Ready && c < 20);
        check("busy_ready_cycle", 16'(c), 16'(WS + 3));
        check("busy_addr",  MemAddr, 16'h0100);
        check("busy_data",  DataIn,  16'h1111);
        check("busy_wdata", MemWData, 16'hA5A5);
        Req = 1'b1; Write = 1'b0; SysBus = 16'h0200; MemRData = 16'h2222;
        c = 0;
        do begin
            @(negedge Clock);
            c++;
            Req = 1'b0; SysBus = 16'hFFFF;
        end while (!MemEn && c < 20);
        check("b2b_memen_cycle", 16'(c), 16'(WS + 2));
        check("b2b_addr", MemAddr, 16'h0200);
        check("b2b_data", DataIn,  16'h2222);
        @(negedge Clock);
        check("b2b_ready", 16'(Ready), 16'd1);

        // External wait held for 3 cycles once the counter has expired
        Req = 1'b1; Write = 1'b0; SysBus = 16'h0300; MemRData = 16'h0BAD;
        en_c = 0; en_data = 16'h0000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clock);
            if (en_c == 0 && MemEn) begin
                en_c = k; en_data = DataIn;
            end
            Req = 1'b0; SysBus = 16'hFFFF;
            if (k == int'(WS) + 1) MemWait = 1'b1;
            if (k == int'(WS) + 4) begin
                MemWait = 1'b0; MemRData = 16'h3333;
            end
        end
`ifdef MEMCTRL_EXT_WAIT_EN
        exp_en_c = int'(WS) + 5; exp_en_data = 16'h3333;
`else
        exp_en_c = int'(WS) + 2; exp_en_data = 16'h0BAD;
`endif
        check("wait_memen_cycle", 16'(en_c), 16'(exp_en_c));
        check("wait_data", en_data, exp_en_data);
        check("wait_ready", 16'(Ready), 16'd1);

        // Asynchronous reset in the middle of a read access
        Req = 1'b1; Write = 1'b0; SysBus = 16'h0400; MemRData = 16'h4444;
        @(negedge Clock);
        Req = 1'b0;
        @(negedge Clock);
        check("arst_pre_oe", 16'(nMemOE), 16'd0);
        #2 nReset = 1'b0;
        #1;
        check("arst_oe",     16'(nMemOE), 16'd1);
        check("arst_we",     16'(nMemWE), 16'd1);
        check("arst_ready",  16'(Ready),  16'd1);
        check("arst_datain", DataIn,      16'h0000);
        check("arst_addr",   MemAddr,     16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            check("arst_memen", 16'(MemEn), 16'd0);
            check("arst_done",  16'(Done),  16'd0);
        end
        nReset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            check("arst_after_memen", 16'(MemEn), 16'd0);
            check("arst_after_ready", 16'(Ready), 16'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
